// File: rtl/onyx_stream_pkg.sv
// -----------------------------------------------------------------------------
// onyx_stream_pkg
// Shared stream definitions for the broadcast fork and the downstream fanout
// ready-merge. Both blocks route a sink by the same select-field bit, so that
// bit lives here rather than in either block.
//   DATA_W       token width (16-bit payload + control/EOS bit)
//   SEL_BIT      bit of each per-sink select field that routes the stream
//   token_t      one stream token
//   fork_state_e fork occupancy: EMPTY (nothing held) / HOLD (token held)
// -----------------------------------------------------------------------------
package onyx_stream_pkg;

  localparam int DATA_W  = 17;
  localparam int SEL_BIT = 6;

  typedef logic [DATA_W-1:0] token_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } fork_state_e;

endpackage

// File: rtl/eager_fanout_fork_if.sv
// -----------------------------------------------------------------------------
// eager_fanout_fork_if
// Stream bundle around the fork: one upstream valid/ready channel and a
// broadcast data bus with per-sink valid/ready.
//   in_data/in_valid/in_ready     upstream token channel
//   out_data                      held token, common to every sink
//   out_valid/out_ready           per-sink handshake, NUM_OUT wide
// modport slave  : the fork itself
// modport master : the environment (upstream producer + sinks)
// -----------------------------------------------------------------------------
interface eager_fanout_fork_if
  import onyx_stream_pkg::*;
#(
  parameter int NUM_OUT = 20
);

  token_t             in_data;
  logic               in_valid;
  logic               in_ready;
  token_t             out_data;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

endinterface

// File: rtl/fanout_target_decode.sv
// -----------------------------------------------------------------------------
// fanout_target_decode
// Purely combinational: decides which sinks a token is routed to.
//   cfg_en   in   NUM_OUT          per-sink enable
//   cfg_sel  in   NUM_OUT*SEL_W    per-sink select, sink i at [i*SEL_W +: SEL_W]
//   target   out  NUM_OUT          sink i targeted = cfg_en[i] & sel_i[SEL_BIT]
// -----------------------------------------------------------------------------
module fanout_target_decode
  import onyx_stream_pkg::*;
#(
  parameter int NUM_OUT = 20,
  parameter int SEL_W   = 8
) (
  input  logic [NUM_OUT-1:0]       cfg_en,
  input  logic [NUM_OUT*SEL_W-1:0] cfg_sel,
  output logic [NUM_OUT-1:0]       target
);

  // Only SEL_BIT of each field matters here; the rest belongs to other users.
  logic unused_sel_bits;
  assign unused_sel_bits = ^cfg_sel;

  always_comb begin
    target = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      target[i] = cfg_en[i] & cfg_sel[i*SEL_W + SEL_BIT];
    end
  end

endmodule

// File: rtl/eager_fanout_fork.sv
// -----------------------------------------------------------------------------
// eager_fanout_fork
// Registered one-to-many broadcast stage with eager per-sink delivery. A token
// is captured together with its target set; each targeted sink takes it in
// whatever cycle it is ready, and the token retires when the last one does.
//   CLK, ASYNCRESET   clock (rising edge), asynchronous active-high reset
//   bus (slave)       upstream token channel + broadcast data, per-sink vld/rdy
//   cfg_en, cfg_sel   static routing config, sampled only when a token loads
//   tok_cnt           tokens retired since reset, saturating at all-ones
// -----------------------------------------------------------------------------
module eager_fanout_fork
  import onyx_stream_pkg::*;
#(
  parameter int NUM_OUT = 20,
  parameter int SEL_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESET,
  eager_fanout_fork_if.slave       bus,
  input  logic [NUM_OUT-1:0]       cfg_en,
  input  logic [NUM_OUT*SEL_W-1:0] cfg_sel,
  output logic [CNT_W-1:0]         tok_cnt
);

  fork_state_e        state_q, state_d;
  logic [NUM_OUT-1:0] pending_q, pending_d;
  token_t             data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_OUT-1:0] target;
  logic [NUM_OUT-1:0] fire;
  logic               full;
  logic               retire;
  logic               accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  fanout_target_decode #(
    .NUM_OUT (NUM_OUT),
    .SEL_W   (SEL_W)
  ) u_decode (
    .cfg_en  (cfg_en),
    .cfg_sel (cfg_sel),
    .target  (target)
  );

  // State register: everything, data included, clears on reset so a token
  // caught mid-delivery is discarded at once.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q   <= ST_EMPTY;
      pending_q <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
    end
  end

  // Outputs and handshake terms. out_valid comes only from registers, so it
  // never depends on out_ready; in_ready may, which gives same-cycle refill.
  always_comb begin
    full          = (state_q == ST_HOLD);
    bus.out_valid = full ? pending_q : '0;
    bus.out_data  = data_q;
    fire          = bus.out_valid & bus.out_ready;
    retire        = full && ((pending_q & ~fire) == '0);
    bus.in_ready  = !full || retire;
    accept        = bus.in_valid && bus.in_ready;
  end

  assign tok_cnt = cnt_q;

  // Next state. A token with an empty target set is accepted and dropped.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    data_d    = data_q;
    cnt_d     = retire ? sat_inc(cnt_q) : cnt_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept && (target != '0)) begin
          data_d    = bus.in_data;
          pending_d = target;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!retire) begin
          pending_d = pending_q & ~fire;
        end else if (accept && (target != '0)) begin
          data_d    = bus.in_data;
          pending_d = target;
        end else begin
          pending_d = '0;
          state_d   = ST_EMPTY;
        end
      end
      default: begin
        state_d   = ST_EMPTY;
        pending_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_eager_fanout_fork.sv
// -----------------------------------------------------------------------------
// tb_eager_fanout_fork
// Drives the fork with directed and random streams and compares every cycle
// against a per-sink delivery-queue model. A second instance with a 2-bit
// counter runs flat out to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_eager_fanout_fork;
  import onyx_stream_pkg::*;

  localparam int N     = 20;
  localparam int SELW  = 8;

  logic              CLK = 1'b0;
  logic              ASYNCRESET = 1'b0;
  logic [N-1:0]      cfg_en = '0;
  logic [N*SELW-1:0] cfg_sel = '0;
  logic [15:0]       tok_cnt;
  logic [1:0]        sat_cnt;

  logic [N-1:0]      nxt_en = '0;
  logic [N*SELW-1:0] nxt_sel = '0;

  eager_fanout_fork_if #(.NUM_OUT(N)) bus ();
  eager_fanout_fork_if #(.NUM_OUT(N)) sat_bus ();

  assign sat_bus.in_valid  = 1'b1;
  assign sat_bus.in_data   = '0;
  assign sat_bus.out_ready = '1;

  eager_fanout_fork #(.NUM_OUT(N), .SEL_W(SELW), .CNT_W(16)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .bus        (bus.slave),
    .cfg_en     (cfg_en),
    .cfg_sel    (cfg_sel),
    .tok_cnt    (tok_cnt)
  );

  eager_fanout_fork #(.NUM_OUT(N), .SEL_W(SELW), .CNT_W(2)) dut_sat (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .bus        (sat_bus.slave),
    .cfg_en     ({N{1'b1}}),
    .cfg_sel    ({(N*SELW){1'b1}}),
    .tok_cnt    (sat_cnt)
  );

  always #5 CLK = ~CLK;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Model: each sink owns a queue of token ids it still has to receive.
  int          sinkq[N][$];
  token_t      tok_data[$];
  int          tok_left[$];
  int unsigned exp_cnt = 0;
  logic        last_in_ready;

  function automatic logic [N-1:0] targets_of(input logic [N-1:0] en,
                                              input logic [N*SELW-1:0] sel);
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) t[i] = en[i] && sel[i*SELW + 6];
    return t;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) sinkq[i].delete();
    exp_cnt = 0;
  endtask

  // One clock cycle: drive at the falling edge, check just after, then
  // advance the model for the coming rising edge.
  task automatic step(input logic v, input token_t d, input logic [N-1:0] rdy);
    logic [N-1:0] exp_vld;
    logic [N-1:0] tgt;
    logic         exp_rdy;
    int           id;
    int           first;
    @(negedge CLK);
    cfg_en        = nxt_en;
    cfg_sel       = nxt_sel;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = rdy;
    #1;
    exp_vld = '0;
    exp_rdy = 1'b1;
    first   = -1;
    for (int i = 0; i < N; i++) begin
      if (sinkq[i].size() > 0) begin
        exp_vld[i] = 1'b1;
        if (first < 0) first = i;
        if (!rdy[i]) exp_rdy = 1'b0;
      end
    end
    chk("out_valid", 64'(bus.out_valid), 64'(exp_vld));
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    chk("tok_cnt", 64'(tok_cnt), 64'(exp_cnt));
    if (first >= 0) chk("out_data", 64'(bus.out_data), 64'(tok_data[sinkq[first][0]]));
    last_in_ready = bus.in_ready;
    for (int i = 0; i < N; i++) begin
      if (sinkq[i].size() > 0 && rdy[i]) begin
        id = sinkq[i].pop_front();
        tok_left[id] = tok_left[id] - 1;
        if (tok_left[id] == 0 && exp_cnt < 32'hFFFF) exp_cnt++;
      end
    end
    if (v && exp_rdy) begin
      tgt = targets_of(cfg_en, cfg_sel);
      if (tgt != '0) begin
        id = tok_data.size();
        tok_data.push_back(d);
        tok_left.push_back($countones(tgt));
        for (int i = 0; i < N; i++) if (tgt[i]) sinkq[i].push_back(id);
      end
    end
  endtask

  function automatic logic [N*SELW-1:0] sel_for(input logic [N-1:0] mask);
    logic [N*SELW-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s[i*SELW + 6] = mask[i];
    return s;
  endfunction

  initial begin
    logic [N-1:0] rdy;
    int           zeros;
    int unsigned  snap;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    #1 ASYNCRESET = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_tok_cnt", 64'(tok_cnt), 64'(0));
    chk("rst_sat_cnt", 64'(sat_cnt), 64'(0));
    @(posedge CLK);
    @(posedge CLK);
    #2 ASYNCRESET = 1'b0;
    model_clear();

    // Test 1: targets {0,3,19}, all ready, four back-to-back tokens.
    nxt_en  = '0;
    nxt_en[0] = 1'b1; nxt_en[3] = 1'b1; nxt_en[19] = 1'b1;
    nxt_sel = sel_for(nxt_en);
    zeros = 0;
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, token_t'(k), '1);
      if (!last_in_ready) zeros++;
    end
    step(1'b0, '0, '1);
    step(1'b0, '0, '1);
    chk("t1_in_ready_low_cycles", 64'(zeros), 64'(0));
    chk("t1_tok_cnt", 64'(tok_cnt), 64'(4));
    chk("sat_cnt_saturated", 64'(sat_cnt), 64'(3));

    // Test 2: targets {0,3}, sink 3 stalls for five cycles.
    nxt_en = '0; nxt_en[0] = 1'b1; nxt_en[3] = 1'b1;
    nxt_sel = sel_for(nxt_en);
    step(1'b1, token_t'(17'h000A), '1);
    rdy = '1; rdy[3] = 1'b0;
    zeros = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, token_t'(17'h000B), rdy);
      if (!last_in_ready) zeros++;
    end
    step(1'b1, token_t'(17'h000B), '1);
    chk("t2_refill_same_cycle", 64'(last_in_ready), 64'(1));
    step(1'b0, '0, '1);
    chk("t2_in_ready_low_cycles", 64'(zeros), 64'(5));

    // Test 3: nothing enabled, tokens are swallowed.
    snap = exp_cnt;
    nxt_en = '0;
    for (int k = 0; k < 3; k++) step(1'b1, token_t'(17'h1F0 + k), '1);
    step(1'b0, '0, '1);
    chk("t3_tok_cnt_unchanged", 64'(tok_cnt), 64'(snap));

    // Test 4: drop sink 5 from the select while it still holds a token.
    nxt_en = '0; nxt_en[0] = 1'b1; nxt_en[5] = 1'b1;
    nxt_sel = sel_for(nxt_en);
    step(1'b1, token_t'(17'h0C0C), '1);
    rdy = '1; rdy[5] = 1'b0;
    step(1'b0, '0, rdy);
    nxt_sel[5*SELW + 6] = 1'b0;
    step(1'b1, token_t'(17'h0D0D), rdy);
    chk("t4_sink5_still_valid", 64'(bus.out_valid[5]), 64'(1));
    step(1'b1, token_t'(17'h0D0D), '1);
    step(1'b0, '0, '1);
    chk("t4_sink5_excluded", 64'(bus.out_valid[5]), 64'(0));

    // Test 5: asynchronous reset while a token is held.
    nxt_en = '0; nxt_en[1] = 1'b1;
    nxt_sel = sel_for(nxt_en);
    step(1'b1, token_t'(17'h1BEEF), '0);
    step(1'b0, '0, '0);
    #2 ASYNCRESET = 1'b1;
    #1;
    chk("t5_out_valid", 64'(bus.out_valid), 64'(0));
    chk("t5_in_ready", 64'(bus.in_ready), 64'(1));
    chk("t5_out_data", 64'(bus.out_data), 64'(0));
    chk("t5_tok_cnt", 64'(tok_cnt), 64'(0));
    chk("t5_sat_cnt", 64'(sat_cnt), 64'(0));
    model_clear();
    @(posedge CLK);
    #2 ASYNCRESET = 1'b0;
    step(1'b0, '0, '1);
    step(1'b0, '0, '1);

    // Random phase: config reshuffled every 50 cycles, biased-ready sinks.
    for (int k = 0; k < 400; k++) begin
      if (k % 50 == 0) begin
        nxt_en = N'($urandom);
        for (int i = 0; i < N; i++) nxt_sel[i*SELW +: SELW] = SELW'($urandom);
        if (k == 100) nxt_en = '1;
      end
      for (int i = 0; i < N; i++) rdy[i] = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 9) < 7, token_t'($urandom), rdy);
    end
    step(1'b0, '0, '1);
    step(1'b0, '0, '1);
    chk("final_sat_cnt", 64'(sat_cnt), 64'(3));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
